// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl
// MEM-stage controller that turns pipeline load/store requests into
// multi-cycle accesses on an external single-port SRAM. While an access is
// in flight, ready is held low so the upstream pipeline registers freeze.
// A request runs as IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE -> IDLE.
// DONE never samples the request, so a frozen request is not issued twice.
//
// Parameters:
//   WAIT_CYCLES  SRAM access cycles per request (1..15)
//   SRAM_BASE    byte address mapped to SRAM word 0
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   ALU_Res       byte address from EX/MEM
//   Val_Rm        store data
//   MEM_R_EN      load request (held while ready=0)
//   MEM_W_EN      store request (held while ready=0; wins over MEM_R_EN)
//   memory_out    registered load data to MEM/WB
//   ready         combinational pipeline-advance flag
//   SRAM_ADDR     SRAM word address
//   SRAM_WDATA    SRAM write data
//   SRAM_RDATA    SRAM read data
//   SRAM_WE_N     active-low SRAM write enable
//   misalign_err  one-cycle misalignment pulse (MEM_MISALIGN_CHECK_EN only)
//
// Build option: define MEM_MISALIGN_CHECK_EN to reject requests whose
// ALU_Res[1:0] != 0. They skip the SRAM, go straight to DONE and pulse
// misalign_err. Without the macro the port is absent and the low address
// bits are ignored.

module mem_stage_sram_ctrl #(
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] SRAM_BASE   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_Res,
    input  logic [31:0] Val_Rm,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    output logic [31:0] memory_out,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    output logic [31:0] SRAM_WDATA,
    input  logic [31:0] SRAM_RDATA,
    output logic        SRAM_WE_N
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        wr_q;
    logic        req;
    logic [31:0] addr_offset;
    logic        unused_addr_bits;

    assign req = MEM_R_EN | MEM_W_EN;

    // Subtracting in 32 bits and keeping bits [19:2] makes addresses below
    // SRAM_BASE wrap modulo 2^18 words without any extra logic.
    assign addr_offset      = ALU_Res - SRAM_BASE;
    assign unused_addr_bits = ^{addr_offset[31:20], addr_offset[1:0]};

`ifdef MEM_MISALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = |ALU_Res[1:0];
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and ready decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        ready     = 1'b1;
        unique case (state)
            IDLE: begin
                if (req) begin
                    ready = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
                    state_nxt = misaligned ? DONE : ACCESS;
`else
                    state_nxt = ACCESS;
`endif
                end
            end
            ACCESS: begin
                ready = 1'b0;
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: counter, latched request and SRAM-facing registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            cnt        <= 4'd0;
            wr_q       <= 1'b0;
            memory_out <= 32'd0;
            SRAM_ADDR  <= 18'd0;
            SRAM_WDATA <= 32'd0;
            SRAM_WE_N  <= 1'b1;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_err <= 1'b0;
`endif
        end else begin
`ifdef MEM_MISALIGN_CHECK_EN
            // Rejected requests reach DONE one edge after IDLE, so setting the
            // flag only on that transition yields a pulse for the DONE cycle.
            misalign_err <= (state == IDLE) && req && misaligned;
`endif
            unique case (state)
                IDLE: begin
`ifdef MEM_MISALIGN_CHECK_EN
                    if (req && !misaligned) begin
`else
                    if (req) begin
`endif
                        cnt        <= 4'(WAIT_CYCLES - 1);
                        SRAM_ADDR  <= addr_offset[19:2];
                        SRAM_WDATA <= Val_Rm;
                        // A simultaneous load and store is treated as a store.
                        wr_q       <= MEM_W_EN;
                        SRAM_WE_N  <= ~MEM_W_EN;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        SRAM_WE_N <= 1'b1;
                        if (!wr_q) begin
                            memory_out <= SRAM_RDATA;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
